// File: rtl/seven_seg_pkg.sv
// Shared constants, segment table and FSM state type for the seven-segment bus monitor.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;

  // Active-high segments {g..a} for nibbles 0..F; entry i is SEG_TABLE[i].
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    HELD     = 2'd2
  } dec_state_t;

endpackage

// File: rtl/seven_segment_decoder_s7tob.sv
// Combinational reverse lookup: active-high segment pattern to hex nibble.
// ok is low when the pattern matches no table entry (nib is then 0).
module s7tob
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nib,
  output logic             ok
);

  always_comb begin
    nib = '0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nib = i[NIB_W-1:0];
        ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Passive monitor of a multiplexed 8-digit seven-segment bus; reassembles the displayed 32-bit value.
// Define SEVSEG_DEC_SYNC_EN to add a 2-flop synchroniser ahead of the input register.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [SEG_W-1:0]      cat_in,
  input  logic [NUM_DIGITS-1:0] an_in,
  output logic [31:0]           val_out,
  output logic                  valid_out,
  output logic                  err_out,
  output logic                  stale_out,
  output logic [NUM_DIGITS-1:0] digit_mask_out
);

  localparam logic [7:0]  SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [31:0] TO_MAX   = TIMEOUT_CYCLES;
  localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 1;

  logic [NUM_DIGITS-1:0] an_src, an_q, an_p;
  logic [SEG_W-1:0]      cat_src, cat_q, cat_p;

`ifdef SEVSEG_DEC_SYNC_EN
  logic [NUM_DIGITS-1:0] an_s1, an_s2;
  logic [SEG_W-1:0]      cat_s1, cat_s2;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      an_s1  <= '1;
      an_s2  <= '1;
      cat_s1 <= '1;
      cat_s2 <= '1;
    end else begin
      an_s1  <= an_in;
      an_s2  <= an_s1;
      cat_s1 <= cat_in;
      cat_s2 <= cat_s1;
    end
  end

  assign an_src  = an_s2;
  assign cat_src = cat_s2;
`else
  assign an_src  = an_in;
  assign cat_src = cat_in;
`endif

  // Idle bus level (all lines high) so reset never looks like a lit digit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      an_q  <= '1;
      cat_q <= '1;
      an_p  <= '1;
      cat_p <= '1;
    end else begin
      an_q  <= an_src;
      cat_q <= cat_src;
      an_p  <= an_q;
      cat_p <= cat_q;
    end
  end

  logic [NUM_DIGITS-1:0] act_an;
  logic [SEG_W-1:0]      seg;
  logic                  digit_active, changed;
  logic [2:0]            idx;

  assign act_an       = ~an_q;
  assign seg          = ~cat_q;
  assign digit_active = $onehot(act_an);
  assign changed      = {an_q, cat_q} != {an_p, cat_p};

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act_an[i]) idx = i[2:0];
    end
  end

  logic [NIB_W-1:0] nib_dec;
  logic             nib_ok;

  s7tob u_s7tob (
    .seg (seg),
    .nib (nib_dec),
    .ok  (nib_ok)
  );

  dec_state_t state, state_nxt;
  logic [7:0] run, run_nxt;
  logic       capture;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  always_comb begin
    run_nxt = run;
    if (!digit_active)                  run_nxt = '0;
    else if (changed || state == IDLE)  run_nxt = 8'd1;
    else if (run != 8'hFF)              run_nxt = run + 8'd1;
  end

  always_comb begin
    state_nxt = SETTLING;
    if (!digit_active)                    state_nxt = IDLE;
    else if (capture)                     state_nxt = HELD;
    else if (state == HELD && !changed)   state_nxt = HELD;
  end

  // A HELD digit is never re-captured until its pattern changes.
  always_comb begin
    capture = digit_active && (state != HELD || changed) && (run_nxt == SETTLE_N);
  end

  logic [NUM_DIGITS-1:0][NIB_W-1:0] nib_q, frame_asm;
  logic [NUM_DIGITS-1:0]            mask, mask_nxt;
  logic                             frame_err;
  logic [31:0]                      tmo;

  always_comb begin
    frame_asm      = nib_q;
    frame_asm[idx] = nib_ok ? nib_dec : '0;
    mask_nxt       = mask | (NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      nib_q     <= '0;
      mask      <= '0;
      frame_err <= 1'b0;
      tmo       <= '0;
      val_out   <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      stale_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (capture) begin
        nib_q     <= frame_asm;
        tmo       <= '0;
        stale_out <= 1'b0;
        if (mask_nxt == '1) begin
          val_out   <= frame_asm;
          valid_out <= 1'b1;
          err_out   <= frame_err | ~nib_ok;
          mask      <= '0;
          frame_err <= 1'b0;
        end else begin
          mask      <= mask_nxt;
          frame_err <= frame_err | ~nib_ok;
        end
      end else begin
        if (tmo != TO_MAX) tmo <= tmo + 32'd1;
        if (tmo == TO_LAST) begin
          mask      <= '0;
          frame_err <= 1'b0;
          stale_out <= 1'b1;
        end
      end
    end
  end

  assign digit_mask_out = mask;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: frames are queued on a scoreboard when driven and checked on valid_out.
module tb_seven_segment_decoder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [6:0]  cat_in;
  logic [7:0]  an_in;
  logic [31:0] val_out;
  logic        valid_out, err_out, stale_out;
  logic [7:0]  digit_mask_out;

  typedef struct packed {
    logic [31:0] val;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  seven_segment_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .cat_in         (cat_in),
    .an_in          (an_in),
    .val_out        (val_out),
    .valid_out      (valid_out),
    .err_out        (err_out),
    .stale_out      (stale_out),
    .digit_mask_out (digit_mask_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h3F; 4'h1: enc = 7'h06; 4'h2: enc = 7'h5B; 4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66; 4'h5: enc = 7'h6D; 4'h6: enc = 7'h7D; 4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F; 4'h9: enc = 7'h6F; 4'hA: enc = 7'h77; 4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39; 4'hD: enc = 7'h5E; 4'hE: enc = 7'h79; default: enc = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic show(input int k, input logic [6:0] segs, input int cycles);
    an_in  = ~(8'h01 << k);
    cat_in = ~segs;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic blank(input logic [7:0] an, input int cycles);
    an_in  = an;
    cat_in = 7'h7F;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic clean_frame(input logic [31:0] v);
    sb.push_back('{val: v, err: 1'b0});
    for (int k = 0; k < 8; k++) show(k, enc(v[4*k +: 4]), 10);
    blank(8'hFF, 2);
    chk("frame_done", sb.size(), 0);
    chk("mask_after_frame", {24'b0, digit_mask_out}, 0);
  endtask

  // Scoreboard consumer: every valid_out pulse must match the oldest queued frame.
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_valid observed=%h expected=no_frame", val_out);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_val", val_out, e.val);
        chk("frame_err", {31'b0, err_out}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0;
    an_in    = 8'hFF;
    cat_in   = 7'h7F;
    repeat (3) @(negedge clk_in);
    chk("rst_val", val_out, 0);
    chk("rst_valid", {31'b0, valid_out}, 0);
    chk("rst_err", {31'b0, err_out}, 0);
    chk("rst_stale", {31'b0, stale_out}, 0);
    chk("rst_mask", {24'b0, digit_mask_out}, 0);
    rst_n_in = 1'b1;
    blank(8'hFF, 3);

    clean_frame(32'hDEADBEEF);

    // Glitch: a 3-cycle "1" on digit 0 must not be captured before the settled "3".
    sb.push_back('{val: 32'h89ABCDE3, err: 1'b0});
    show(0, 7'h06, 3);
    show(0, 7'h4F, 2);
    chk("glitch_no_capture", {24'b0, digit_mask_out}, 0);
    show(0, 7'h4F, 8);
    chk("glitch_mask", {24'b0, digit_mask_out}, 32'h01);
    for (int k = 1; k < 8; k++) show(k, enc(4'(32'h89ABCDE3 >> (4*k))), 10);
    blank(8'hFF, 2);
    chk("glitch_frame_done", sb.size(), 0);

    // Blank and multi-hot gaps between digits leave the mask alone.
    sb.push_back('{val: 32'h13579BDF, err: 1'b0});
    for (int k = 0; k < 8; k++) begin
      logic [7:0] mexp;
      logic [31:0] v;
      v = 32'h13579BDF;
      mexp = 8'((16'h1 << (k + 1)) - 1);
      show(k, enc(v[4*k +: 4]), 10);
      if (k < 7) begin
        blank((k % 2 == 0) ? 8'hFF : 8'hFC, 50);
        chk("gap_mask", {24'b0, digit_mask_out}, {24'b0, mexp});
      end
    end
    blank(8'hFF, 2);
    chk("gap_frame_done", sb.size(), 0);

    // Undecodable pattern on digit 5 stores 0 and flags the frame.
    sb.push_back('{val: 32'hA505A5A5, err: 1'b1});
    for (int k = 0; k < 8; k++) show(k, (k == 5) ? 7'h01 : enc((k % 2 == 0) ? 4'h5 : 4'hA), 10);
    blank(8'hFF, 2);
    chk("bad_frame_done", sb.size(), 0);
    clean_frame(32'h0F1E2D3C);

    // Timeout: partial frame dropped, stale raised, next capture clears stale.
    show(0, enc(4'h1), 10);
    show(1, enc(4'h2), 10);
    show(2, enc(4'h3), 10);
    blank(8'hFF, 50);
    chk("pre_timeout_mask", {24'b0, digit_mask_out}, 32'h07);
    chk("pre_timeout_stale", {31'b0, stale_out}, 0);
    blank(8'hFF, 60);
    chk("timeout_stale", {31'b0, stale_out}, 1);
    chk("timeout_mask", {24'b0, digit_mask_out}, 0);
    chk("timeout_val_held", val_out, 32'h0F1E2D3C);
    show(0, enc(4'h9), 10);
    chk("stale_cleared", {31'b0, stale_out}, 0);
    chk("mask_after_stale", {24'b0, digit_mask_out}, 32'h01);

    // Async reset mid-frame after 6 captures.
    for (int k = 1; k < 6; k++) show(k, enc(4'h4), 10);
    chk("pre_reset_mask", {24'b0, digit_mask_out}, 32'h3F);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("arst_val", val_out, 0);
    chk("arst_mask", {24'b0, digit_mask_out}, 0);
    chk("arst_stale", {31'b0, stale_out}, 0);
    chk("arst_valid", {31'b0, valid_out}, 0);
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    blank(8'hFF, 3);
    chk("arst_mask_after", {24'b0, digit_mask_out}, 0);
    clean_frame(32'h01234567);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
